host_ctrl: RTL and testbench

Host-side sequencer for the CPU core's external maintenance port (cmd / addr_in / data_in / data_out). Accepts one command at a time over a valid/ready channel and returns one response per command. Supported commands: load I-cache words, load D-cache words, read back registers or D-cache words, run the core for a bounded cycle count. Owns the core's reset, holding it in reset whenever it is not running.

---
 rtl/host_ctrl_pkg.sv | 37 +++
 rtl/host_ctrl.sv | 172 +++++++++++++++++
 tb/tb_host_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_ctrl_pkg.sv
// Shared encodings for the host-side maintenance sequencer: host op codes,
// FSM states, core-port command codes and the error response word.
package host_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_WR_I   = 3'b000,
    OP_WR_D   = 3'b001,
    OP_RD_REG = 3'b010,
    OP_RD_D   = 3'b011,
    OP_RUN    = 3'b100
  } host_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE,
    ST_RUN,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    CMD_REG_RD = 2'b00,
    CMD_IWR    = 2'b01,
    CMD_DRD    = 2'b10,
    CMD_DWR    = 2'b11
  } core_cmd_e;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  // Word index (byte address >> 2) must fall inside a cache of the given depth.
  function automatic logic word_in_range(input logic [29:0] word_idx,
                                         input int unsigned words);
    return {2'b00, word_idx} < words;
  endfunction

endpackage

// File: rtl/host_ctrl.sv
// Host command sequencer for the core maintenance port: one command in, one
// response out, core held in reset except while a RUN command is counting.
module host_ctrl
  import host_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [2:0]  host_op,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        cpu_reset,
  output logic [1:0]  cmd,
  output logic [31:0] addr_in,
  output logic [31:0] data_in,
  input  logic [31:0] data_out
);

  state_e      state_q;
  logic        host_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;
  logic        cpu_reset_q;
  core_cmd_e   cmd_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] run_cnt_q;
  logic [31:0] run_len_q;

  host_op_e op_in;
  logic     op_ok;
  logic     accept;

  assign accept = host_valid && host_ready_q;

  always_comb begin
    op_in = host_op_e'(host_op);
    op_ok = 1'b0;
    case (op_in)
      OP_WR_I:           op_ok = word_in_range(host_addr[31:2], IMEM_WORDS);
      OP_WR_D, OP_RD_D:  op_ok = word_in_range(host_addr[31:2], DMEM_WORDS);
      OP_RD_REG, OP_RUN: op_ok = 1'b1;
      default:           op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      host_ready_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      cpu_reset_q  <= 1'b1;
      cmd_q        <= CMD_REG_RD;
      addr_q       <= '0;
      data_q       <= '0;
      run_cnt_q    <= '0;
      run_len_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            host_ready_q <= 1'b0;
            if (!op_ok) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= ERR_WORD;
            end else begin
              case (op_in)
                OP_WR_I, OP_WR_D: begin
                  state_q <= ST_WRITE;
                  cmd_q   <= (op_in == OP_WR_I) ? CMD_IWR : CMD_DWR;
                  addr_q  <= host_addr;
                  data_q  <= host_data;
                end
                OP_RD_REG: begin
                  state_q <= ST_RD_ISSUE;
                  cmd_q   <= CMD_REG_RD;
                  addr_q  <= {27'b0, host_addr[4:0]};
                end
                OP_RD_D: begin
                  state_q <= ST_RD_ISSUE;
                  cmd_q   <= CMD_DRD;
                  addr_q  <= host_addr;
                end
                OP_RUN: begin
                  // A zero count answers at once and never releases the core.
                  if (host_data == '0) begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                  end else begin
                    state_q     <= ST_RUN;
                    cpu_reset_q <= 1'b0;
                    run_cnt_q   <= host_data;
                    run_len_q   <= host_data;
                  end
                end
                default: state_q <= ST_IDLE;
              endcase
            end
          end
        end

        ST_WRITE: begin
          state_q     <= ST_RESP;
          cmd_q       <= CMD_REG_RD;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end

        ST_RD_ISSUE: begin
          state_q <= ST_RD_CAPTURE;
        end

        // Second read cycle lets the D-cache's registered output settle.
        ST_RD_CAPTURE: begin
          state_q     <= ST_RESP;
          cmd_q       <= CMD_REG_RD;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= data_out;
        end

        ST_RUN: begin
          if (run_cnt_q == 32'd1) begin
            state_q     <= ST_RESP;
            cpu_reset_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= run_len_q;
          end else begin
            run_cnt_q <= run_cnt_q - 32'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_q      <= ST_IDLE;
            rsp_valid_q  <= 1'b0;
            host_ready_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_ready = host_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign cmd        = cmd_q;
  assign addr_in    = addr_q;
  assign data_in    = data_q;

endmodule

// File: tb/tb_host_ctrl.sv
// Scoreboard bench for host_ctrl: a toy core stub on the maintenance port, a
// command-level reference model feeding an expectation queue, and a monitor.
module tb_host_ctrl;
  import host_ctrl_pkg::*;

  localparam int unsigned IMW = 64;
  localparam int unsigned DMW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [2:0]  host_op;
  logic [31:0] host_addr;
  logic [31:0] host_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cpu_reset;
  logic [1:0]  cmd;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [31:0] data_out;

  host_ctrl #(.IMEM_WORDS(IMW), .DMEM_WORDS(DMW)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_op(host_op),
    .host_addr(host_addr), .host_data(host_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cpu_reset(cpu_reset), .cmd(cmd), .addr_in(addr_in), .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic bit is_addi(input logic [31:0] w);
    return (w[6:0] == 7'h13) && (w[14:12] == 3'b000);
  endfunction

  function automatic logic [31:0] addi_imm(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  // Core stub: one instruction per cycle out of reset (only ADDI does
  // anything), registered read data on the port for both reads.
  logic [31:0] core_imem [IMW];
  logic [31:0] core_dmem [DMW];
  logic [31:0] core_rf   [32];
  int unsigned core_pc = 0;
  bit          core_init = 1'b0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (!core_init) begin
      for (int unsigned i = 0; i < IMW; i++) core_imem[i] <= '0;
      for (int unsigned i = 0; i < DMW; i++) core_dmem[i] <= '0;
      for (int unsigned i = 0; i < 32; i++) core_rf[i] <= '0;
      data_out  <= '0;
      core_init <= 1'b1;
    end else begin
      if (cpu_reset) core_pc <= 0;
      else begin
        w = core_imem[core_pc];
        if (is_addi(w) && w[11:7] != 5'd0)
          core_rf[w[11:7]] <= core_rf[w[19:15]] + addi_imm(w);
        core_pc <= (core_pc + 1) % IMW;
      end
      case (cmd)
        2'b01:   core_imem[addr_in[31:2] % IMW] <= data_in;
        2'b11:   core_dmem[addr_in[31:2] % DMW] <= data_in;
        2'b10:   data_out <= core_dmem[addr_in[31:2] % DMW];
        default: data_out <= core_rf[addr_in[4:0]];
      endcase
    end
  end

  // Reference model: architectural view of caches and registers per command.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned lat;
    int unsigned nwr;
    logic [1:0]  wcmd;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int unsigned nlow;
    int unsigned ndrd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_imem [IMW];
  logic [31:0] m_dmem [DMW];
  logic [31:0] m_rf   [32];

  function automatic void model_run(input int unsigned n);
    int unsigned pc = 0;
    logic [31:0] w;
    for (int unsigned i = 0; i < n; i++) begin
      w = m_imem[pc];
      if (is_addi(w) && w[11:7] != 5'd0) m_rf[w[11:7]] = m_rf[w[19:15]] + addi_imm(w);
      pc = (pc + 1) % IMW;
    end
  endfunction

  function automatic exp_t model_cmd(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [31:0] data);
    exp_t        e;
    logic [31:0] widx;
    widx    = {2'b00, addr[31:2]};
    e.data  = ERR_WORD; e.err  = 1'b1; e.lat   = 1; e.nwr   = 0;
    e.wcmd  = 2'b00;    e.waddr = '0;  e.wdata = '0; e.nlow = 0; e.ndrd = 0;
    case (op)
      3'd0: if (widx < IMW) begin
        m_imem[widx] = data;
        e.data = '0; e.err = 1'b0; e.lat = 2; e.nwr = 1;
        e.wcmd = 2'b01; e.waddr = addr; e.wdata = data;
      end
      3'd1: if (widx < DMW) begin
        m_dmem[widx] = data;
        e.data = '0; e.err = 1'b0; e.lat = 2; e.nwr = 1;
        e.wcmd = 2'b11; e.waddr = addr; e.wdata = data;
      end
      3'd2: begin
        e.data = m_rf[addr[4:0]]; e.err = 1'b0; e.lat = 3;
      end
      3'd3: if (widx < DMW) begin
        e.data = m_dmem[widx]; e.err = 1'b0; e.lat = 3; e.ndrd = 2;
      end
      3'd4: begin
        e.err = 1'b0;
        if (data == '0) begin
          e.data = '0; e.lat = 1;
        end else begin
          model_run(data);
          e.data = data; e.lat = data + 1; e.nlow = data;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Acceptance tracking on the active edge; everything else at negedge.
  int unsigned cyc = 0;
  int unsigned acc_edge = 0;
  int unsigned acc_seq = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (host_valid === 1'b1 && host_ready === 1'b1 && reset === 1'b0) begin
      acc_edge <= cyc + 1;
      acc_seq  <= acc_seq + 1;
    end
  end

  int unsigned seen_seq = 0;
  int unsigned rsp_lat = 0, nwr = 0, nlow = 0, ndrd = 0, viol = 0;
  logic [1:0]  wcmd_s;
  logic [31:0] waddr_s, wdata_s, hold_data;
  logic        hold_err;
  bit          seen = 1'b0;
  bit          rand_bp = 1'b0;
  int unsigned bp_left = 0;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (acc_seq != seen_seq) begin
      seen_seq = acc_seq;
      rsp_lat = 0; nwr = 0; nlow = 0; ndrd = 0;
    end
    if (cpu_reset === 1'b0) nlow++;
    if (cpu_reset === 1'b0 && cmd[0] === 1'b1) viol++;
    if (cmd === 2'b01 || cmd === 2'b11) begin
      nwr++; wcmd_s = cmd; waddr_s = addr_in; wdata_s = data_in;
    end
    if (cmd === 2'b10) ndrd++;
    if (rsp_valid === 1'b1) begin
      if (rsp_lat == 0) rsp_lat = cyc - acc_edge + 1;
      check("host_ready_during_rsp", {31'b0, host_ready}, 32'd0);
      if (seen) begin
        check("rsp_data_stable", rsp_data, hold_data);
        check("rsp_err_stable", {31'b0, rsp_err}, {31'b0, hold_err});
      end else begin
        seen = 1'b1; hold_data = rsp_data; hold_err = rsp_err;
      end
      if (bp_left > 0) begin
        rsp_ready = 1'b0; bp_left--;
      end else begin
        rsp_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (rsp_ready) begin
        seen = 1'b0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got data %h err %b, required no response", rsp_data, rsp_err);
        end else begin
          e_mon = exp_q.pop_front();
          check("rsp_data", rsp_data, e_mon.data);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e_mon.err});
          check("rsp_latency", rsp_lat, e_mon.lat);
          check("core_write_cycles", nwr, e_mon.nwr);
          check("run_cycles", nlow, e_mon.nlow);
          check("dcache_read_cycles", ndrd, e_mon.ndrd);
          if (e_mon.nwr != 0) begin
            check("write_cmd", {30'b0, wcmd_s}, {30'b0, e_mon.wcmd});
            check("write_addr", waddr_s, e_mon.waddr);
            check("write_data", wdata_s, e_mon.wdata);
          end
        end
      end
    end else begin
      seen = 1'b0;
      rsp_ready = rand_bp ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input bit expect_rsp);
    int unsigned waited = 0;
    while (host_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (host_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL host_ready_timeout: got %b, required 1", host_ready);
      return;
    end
    if (expect_rsp) exp_q.push_back(model_cmd(op, addr, data));
    host_valid = 1'b1; host_op = op; host_addr = addr; host_data = data;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned waited = 0;
    while ((exp_q.size() != 0 || host_ready !== 1'b1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || host_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_op = '0; host_addr = '0; host_data = '0;
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < IMW; i++) m_imem[i] = '0;
    for (int unsigned i = 0; i < DMW; i++) m_dmem[i] = '0;
    for (int unsigned i = 0; i < 32; i++) m_rf[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_host_ready", {31'b0, host_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("reset_cmd", {30'b0, cmd}, 32'd0);
    check("reset_addr_in", addr_in, 32'd0);
    check("reset_data_in", data_in, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'h8, 32'h00500093, 1'b1);
    issue(3'd1, 32'h10, 32'hCAFEF00D, 1'b1);
    issue(3'd3, 32'h10, 32'h0, 1'b1);
    issue(3'd4, 32'h0, 32'd8, 1'b1);
    issue(3'd2, 32'h1, 32'h0, 1'b1);
    issue(3'd0, 4 * IMW, 32'h12345678, 1'b1);
    issue(3'd7, 32'h0, 32'h0, 1'b1);
    issue(3'd4, 32'h0, 32'd0, 1'b1);
    drain();

    bp_left = 5;
    issue(3'd3, 32'h10, 32'h0, 1'b1);
    drain();
    check("bp_consumed", bp_left, 32'd0);

    // Abort RUN 100 after 40 running cycles; the loaded program is idempotent.
    issue(3'd4, 32'h0, 32'd100, 1'b0);
    check("abort_run_started", {31'b0, cpu_reset}, 32'd0);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_host_ready", {31'b0, host_ready}, 32'd1);
    reset = 1'b0;
    model_run(40);
    repeat (110) @(negedge clk);
    check("abort_still_idle", {31'b0, host_ready}, 32'd1);
    check("abort_core_held", {31'b0, cpu_reset}, 32'd1);
    issue(3'd2, 32'hFFFF_FFE1, 32'h0, 1'b1);
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int unsigned k;
      logic [2:0]  op;
      logic [31:0] a, d, idx;
      logic [11:0] imm;
      logic [4:0]  rs1, rd;
      k   = $urandom_range(0, 99);
      d   = $urandom();
      idx = ($urandom_range(0, 6) == 0) ? $urandom_range(IMW - 1, IMW + 3) : $urandom_range(0, IMW - 1);
      a   = {idx[29:0], 2'($urandom_range(0, 3))};
      if (k < 20) begin
        op = 3'd0;
        if ($urandom_range(0, 1) == 1) begin
          imm = 12'($urandom_range(0, 4095));
          rs1 = 5'($urandom_range(0, 31));
          rd  = 5'($urandom_range(0, 31));
          d   = {imm, rs1, 3'b000, rd, 7'h13};
        end
      end else if (k < 40) op = 3'd1;
      else if (k < 55) begin op = 3'd2; a = $urandom(); end
      else if (k < 75) op = 3'd3;
      else if (k < 90) begin op = 3'd4; d = $urandom_range(0, 12); end
      else op = 3'($urandom_range(5, 7));
      issue(op, a, d, 1'b1);
    end
    drain();
    rand_bp = 1'b0;
    @(negedge clk);

    check("no_write_while_running", viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
